// File: rtl/grasspopper_pkg.sv
// ---------------------------------------------------------------------------
// grasspopper_pkg
// Shared definitions for the Grasshopper (GOST R 34.12-2015) key schedule.
// Contents:
//   KEY_W, BLK_W, N_ROUNDKEYS, N_FEISTEL  fixed widths and counts
//   kstate_t                             key expander FSM states
//   PI_SBOX                              byte substitution table (pi)
//   L_COEF                               linear-layer coefficients, a15..a0
//   ITER_C                               iteration constants C_1..C_32
//   gf_mul / lin_s / lin_r / lin_l       field multiply and the S, R, L maps
// ---------------------------------------------------------------------------
package grasspopper_pkg;

  localparam int KEY_W       = 256;
  localparam int BLK_W       = 128;
  localparam int N_ROUNDKEYS = 10;
  localparam int N_FEISTEL   = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } kstate_t;

  localparam logic [7:0] PI_SBOX [0:255] = '{
    8'hFC, 8'hEE, 8'hDD, 8'h11, 8'hCF, 8'h6E, 8'h31, 8'h16, 8'hFB, 8'hC4, 8'hFA, 8'hDA, 8'h23, 8'hC5, 8'h04, 8'h4D,
    8'hE9, 8'h77, 8'hF0, 8'hDB, 8'h93, 8'h2E, 8'h99, 8'hBA, 8'h17, 8'h36, 8'hF1, 8'hBB, 8'h14, 8'hCD, 8'h5F, 8'hC1,
    8'hF9, 8'h18, 8'h65, 8'h5A, 8'hE2, 8'h5C, 8'hEF, 8'h21, 8'h81, 8'h1C, 8'h3C, 8'h42, 8'h8B, 8'h01, 8'h8E, 8'h4F,
    8'h05, 8'h84, 8'h02, 8'hAE, 8'hE3, 8'h6A, 8'h8F, 8'hA0, 8'h06, 8'h0B, 8'hED, 8'h98, 8'h7F, 8'hD4, 8'hD3, 8'h1F,
    8'hEB, 8'h34, 8'h2C, 8'h51, 8'hEA, 8'hC8, 8'h48, 8'hAB, 8'hF2, 8'h2A, 8'h68, 8'hA2, 8'hFD, 8'h3A, 8'hCE, 8'hCC,
    8'hB5, 8'h70, 8'h0E, 8'h56, 8'h08, 8'h0C, 8'h76, 8'h12, 8'hBF, 8'h72, 8'h13, 8'h47, 8'h9C, 8'hB7, 8'h5D, 8'h87,
    8'h15, 8'hA1, 8'h96, 8'h29, 8'h10, 8'h7B, 8'h9A, 8'hC7, 8'hF3, 8'h91, 8'h78, 8'h6F, 8'h9D, 8'h9E, 8'hB2, 8'hB1,
    8'h32, 8'h75, 8'h19, 8'h3D, 8'hFF, 8'h35, 8'h8A, 8'h7E, 8'h6D, 8'h54, 8'hC6, 8'h80, 8'hC3, 8'hBD, 8'h0D, 8'h57,
    8'hDF, 8'hF5, 8'h24, 8'hA9, 8'h3E, 8'hA8, 8'h43, 8'hC9, 8'hD7, 8'h79, 8'hD6, 8'hF6, 8'h7C, 8'h22, 8'hB9, 8'h03,
    8'hE0, 8'h0F, 8'hEC, 8'hDE, 8'h7A, 8'h94, 8'hB0, 8'hBC, 8'hDC, 8'hE8, 8'h28, 8'h50, 8'h4E, 8'h33, 8'h0A, 8'h4A,
    8'hA7, 8'h97, 8'h60, 8'h73, 8'h1E, 8'h00, 8'h62, 8'h44, 8'h1A, 8'hB8, 8'h38, 8'h82, 8'h64, 8'h9F, 8'h26, 8'h41,
    8'hAD, 8'h45, 8'h46, 8'h92, 8'h27, 8'h5E, 8'h55, 8'h2F, 8'h8C, 8'hA3, 8'hA5, 8'h7D, 8'h69, 8'hD5, 8'h95, 8'h3B,
    8'h07, 8'h58, 8'hB3, 8'h40, 8'h86, 8'hAC, 8'h1D, 8'hF7, 8'h30, 8'h37, 8'h6B, 8'hE4, 8'h88, 8'hD9, 8'hE7, 8'h89,
    8'hE1, 8'h1B, 8'h83, 8'h49, 8'h4C, 8'h3F, 8'hF8, 8'hFE, 8'h8D, 8'h53, 8'hAA, 8'h90, 8'hCA, 8'hD8, 8'h85, 8'h61,
    8'h20, 8'h71, 8'h67, 8'hA4, 8'h2D, 8'h2B, 8'h09, 8'h5B, 8'hCB, 8'h9B, 8'h25, 8'hD0, 8'hBE, 8'hE5, 8'h6C, 8'h52,
    8'h59, 8'hA6, 8'h74, 8'hD2, 8'hE6, 8'hF4, 8'hB4, 8'hC0, 8'hD1, 8'h66, 8'hAF, 8'hC2, 8'h39, 8'h4B, 8'h63, 8'hB6
  };

  // Entry 0 multiplies the most significant byte (a15), entry 15 the least (a0).
  localparam logic [7:0] L_COEF [0:15] = '{
    8'd148, 8'd32, 8'd133, 8'd16, 8'd194, 8'd192, 8'd1, 8'd251,
    8'd1, 8'd192, 8'd194, 8'd16, 8'd133, 8'd32, 8'd148, 8'd1
  };

  // Multiply in GF(2^8) modulo x^8+x^7+x^6+x+1 (reduction byte 0xC3).
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'hC3) : {x[6:0], 1'b0};
    end
    return p;
  endfunction

  function automatic logic [BLK_W-1:0] lin_s(input logic [BLK_W-1:0] a);
    logic [BLK_W-1:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = PI_SBOX[a[8*i +: 8]];
    return r;
  endfunction

  // One LFSR-like step: the new top byte is the weighted sum, the rest shifts down.
  function automatic logic [BLK_W-1:0] lin_r(input logic [BLK_W-1:0] a);
    logic [7:0] l;
    l = 8'h00;
    for (int i = 0; i < 16; i++) l = l ^ gf_mul(L_COEF[i], a[BLK_W-1-8*i -: 8]);
    return {l, a[BLK_W-1:8]};
  endfunction

  function automatic logic [BLK_W-1:0] lin_l(input logic [BLK_W-1:0] a);
    logic [BLK_W-1:0] r;
    r = a;
    for (int i = 0; i < 16; i++) r = lin_r(r);
    return r;
  endfunction

  // Entry i holds C_(i+1) = L(Vec128(i+1)); evaluated at elaboration time.
  typedef logic [N_FEISTEL-1:0][BLK_W-1:0] iter_tab_t;

  function automatic iter_tab_t build_iter_tab();
    iter_tab_t t;
    t = '0;
    for (int i = 0; i < N_FEISTEL; i++) t[i] = lin_l({120'h0, 8'(i + 1)});
    return t;
  endfunction

  localparam iter_tab_t ITER_C = build_iter_tab();

endpackage

// File: rtl/key_feistel_round.sv
// ---------------------------------------------------------------------------
// key_feistel_round
// One combinational Feistel iteration of the Grasshopper key schedule:
//   (a1_next, a0_next) = (L(S(a1 ^ c)) ^ a0, a1)
// Ports:
//   a1, a0    in   128  current Feistel pair
//   c         in   128  iteration constant C_n
//   a1_next   out  128  updated left half
//   a0_next   out  128  updated right half (old left half)
// ---------------------------------------------------------------------------
module key_feistel_round
  import grasspopper_pkg::*;
(
  input  logic [BLK_W-1:0] a1,
  input  logic [BLK_W-1:0] a0,
  input  logic [BLK_W-1:0] c,
  output logic [BLK_W-1:0] a1_next,
  output logic [BLK_W-1:0] a0_next
);

  always_comb begin
    a1_next = lin_l(lin_s(a1 ^ c)) ^ a0;
    a0_next = a1;
  end

endmodule

// File: rtl/round_key_expander.sv
// ---------------------------------------------------------------------------
// round_key_expander
// Sequential Grasshopper key schedule: takes a 256-bit master key, runs the
// 32 Feistel iterations one per clock, stores K1..K10 and serves them through
// a registered read port indexed by stage number.
// Ports:
//   clk           in   1    clock, posedge
//   rst           in   1    synchronous active-high reset
//   key_valid_i   in   1    master key present on key_i
//   key_ready_o   out  1    can accept a key (IDLE or DONE)
//   key_i         in   256  master key, [255:128] -> K1, [127:0] -> K2
//   keys_valid_o  out  1    all ten round keys valid (DONE)
//   busy_o        out  1    expansion in progress (RUN)
//   key_idx_i     in   4    stage number 1..10, anything else reads zero
//   round_key_o   out  128  registered round key for key_idx_i
//   zeroize_i     in   1    wipe all key material (GRASS_KEY_ZEROIZE_EN only)
// Build option: define GRASS_KEY_ZEROIZE_EN to add the zeroize_i port.
// ---------------------------------------------------------------------------
module round_key_expander
  import grasspopper_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
`ifdef GRASS_KEY_ZEROIZE_EN
  input  logic              zeroize_i,
`endif
  input  logic              key_valid_i,
  output logic              key_ready_o,
  input  logic [KEY_W-1:0]  key_i,
  output logic              keys_valid_o,
  output logic              busy_o,
  input  logic [3:0]        key_idx_i,
  output logic [BLK_W-1:0]  round_key_o
);

  kstate_t          state;
  logic [5:0]       cnt;
  logic [BLK_W-1:0] a1;
  logic [BLK_W-1:0] a0;
  logic [BLK_W-1:0] round_keys [N_ROUNDKEYS];

  logic [BLK_W-1:0] c_n;
  logic [BLK_W-1:0] a1_nx;
  logic [BLK_W-1:0] a0_nx;
  logic [BLK_W-1:0] rd_data;
  logic [4:0]       c_sel;
  logic             clear_req;
  logic             accept;

  // Wipe request: reset always, zeroize only when the option is built in.
`ifdef GRASS_KEY_ZEROIZE_EN
  assign clear_req = rst || zeroize_i;
`else
  assign clear_req = rst;
`endif

  assign accept = key_valid_i && key_ready_o;

  // Counter runs 1..32; the table is stored zero-based so round n uses entry n-1.
  assign c_sel = 5'(cnt - 6'd1);
  assign c_n   = ITER_C[c_sel];

  key_feistel_round u_round (
    .a1      (a1),
    .a0      (a0),
    .c       (c_n),
    .a1_next (a1_nx),
    .a0_next (a0_nx)
  );

  // Read mux: stage numbers 1..10 map onto storage slots 0..9, others give zero.
  always_comb begin
    rd_data = '0;
    for (int k = 0; k < N_ROUNDKEYS; k++) begin
      if (key_idx_i == 4'(k + 1)) rd_data = round_keys[k];
    end
  end

  // Main FSM: accept a key, iterate the Feistel network, latch every eighth
  // round pair into storage, and register the read port and status flags.
  always_ff @(posedge clk) begin
    if (clear_req) begin
      state        <= IDLE;
      cnt          <= '0;
      a1           <= '0;
      a0           <= '0;
      round_key_o  <= '0;
      key_ready_o  <= 1'b1;
      busy_o       <= 1'b0;
      keys_valid_o <= 1'b0;
      for (int k = 0; k < N_ROUNDKEYS; k++) round_keys[k] <= '0;
    end else begin
      round_key_o <= rd_data;
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            round_keys[0] <= key_i[KEY_W-1:BLK_W];
            round_keys[1] <= key_i[BLK_W-1:0];
            a1            <= key_i[KEY_W-1:BLK_W];
            a0            <= key_i[BLK_W-1:0];
            cnt           <= 6'd1;
            state         <= RUN;
            key_ready_o   <= 1'b0;
            busy_o        <= 1'b1;
            keys_valid_o  <= 1'b0;
          end
        end
        RUN: begin
          a1 <= a1_nx;
          a0 <= a0_nx;
          // Rounds 8, 16, 24, 32 yield K3/K4 .. K9/K10 (slots 2m and 2m+1).
          for (int m = 1; m <= 4; m++) begin
            if (cnt == 6'(8 * m)) begin
              round_keys[2*m]   <= a1_nx;
              round_keys[2*m+1] <= a0_nx;
            end
          end
          if (cnt == 6'(N_FEISTEL)) begin
            state        <= DONE;
            key_ready_o  <= 1'b1;
            busy_o       <= 1'b0;
            keys_valid_o <= 1'b1;
          end else begin
            cnt <= cnt + 6'd1;
          end
        end
        default: begin
          state        <= IDLE;
          key_ready_o  <= 1'b1;
          busy_o       <= 1'b0;
          keys_valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_round_key_expander.sv
// ---------------------------------------------------------------------------
// tb_round_key_expander
// Self-checking bench for round_key_expander: standard key vector, handshake
// ignore-while-busy, write/read collision, out-of-range reads, reset mid-run,
// re-key from DONE and (with GRASS_KEY_ZEROIZE_EN) zeroize.
// ---------------------------------------------------------------------------
module tb_round_key_expander;

  localparam logic [255:0] STD_KEY = 256'h8899aabbccddeeff0011223344556677fedcba98765432100123456789abcdef;
  localparam logic [255:0] ALT_KEY = 256'h0f1e2d3c4b5a69788796a5b4c3d2e1f000112233445566778899aabbccddeeff;
  localparam logic [127:0] STD_K3  = 128'hdb31485315694343228d6aef8cc78c44;
  localparam logic [127:0] STD_K10 = 128'h72e9dd7416bcf45b755dbaa88e4a4043;

  typedef struct {
    logic [3:0]   idx;
    logic [127:0] expected;
    string        name;
  } read_vec_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         zeroize_i;
  logic         key_valid_i;
  logic         key_ready_o;
  logic [255:0] key_i;
  logic         keys_valid_o;
  logic         busy_o;
  logic [3:0]   key_idx_i;
  logic [127:0] round_key_o;

  int           n_checks = 0;
  int           n_errors = 0;
  int           cycle_count = 0;
  int           t_acc;
  logic [127:0] exp_q [$];
  string        name_q [$];
  read_vec_t    std_vec [8];

  round_key_expander dut (
    .clk          (clk),
    .rst          (rst),
`ifdef GRASS_KEY_ZEROIZE_EN
    .zeroize_i    (zeroize_i),
`endif
    .key_valid_i  (key_valid_i),
    .key_ready_o  (key_ready_o),
    .key_i        (key_i),
    .keys_valid_o (keys_valid_o),
    .busy_o       (busy_o),
    .key_idx_i    (key_idx_i),
    .round_key_o  (round_key_o)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
    cycle_count++;
  endtask

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Drive a key for one edge, then drop key_valid_i.
  task automatic applyStimulus(input logic valid, input logic [255:0] key);
    key_valid_i = valid;
    key_i       = key;
    tick();
    key_valid_i = 1'b0;
  endtask

  // Present an index, queue the expectation, compare once the registered data appears.
  task automatic readKey(input logic [3:0] idx, input logic [127:0] expected, input string name);
    key_idx_i = idx;
    exp_q.push_back(expected);
    name_q.push_back(name);
    tick();
    checkOutput(name_q.pop_front(), round_key_o, exp_q.pop_front());
  endtask

  // Wait (bounded) for keys_valid_o and check it rose 32 edges after the accept edge.
  task automatic waitDone(input int start, input string name);
    int waited;
    waited = 0;
    while (!keys_valid_o && waited < 64) begin
      tick();
      waited++;
    end
    checkOutput(name, 128'(cycle_count - start), 128'd32);
  endtask

  task automatic runStdTable(input string tag);
    for (int i = 0; i < 8; i++) readKey(std_vec[i].idx, std_vec[i].expected, {tag, "_", std_vec[i].name});
  endtask

  initial begin
    std_vec[0] = '{idx: 4'd1,  expected: 128'h8899aabbccddeeff0011223344556677, name: "k1"};
    std_vec[1] = '{idx: 4'd2,  expected: 128'hfedcba98765432100123456789abcdef, name: "k2"};
    std_vec[2] = '{idx: 4'd3,  expected: STD_K3,                               name: "k3"};
    std_vec[3] = '{idx: 4'd4,  expected: 128'h3d4553d8e9cfec6815ebadc40a9ffd04, name: "k4"};
    std_vec[4] = '{idx: 4'd10, expected: STD_K10,                              name: "k10"};
    std_vec[5] = '{idx: 4'd0,  expected: 128'h0,                               name: "idx0"};
    std_vec[6] = '{idx: 4'd11, expected: 128'h0,                               name: "idx11"};
    std_vec[7] = '{idx: 4'd15, expected: 128'h0,                               name: "idx15"};

    rst         = 1'b1;
    zeroize_i   = 1'b0;
    key_valid_i = 1'b0;
    key_i       = '0;
    key_idx_i   = 4'd0;
    tick();
    tick();
    checkOutput("reset_ready", 128'(key_ready_o), 128'd1);
    checkOutput("reset_valid", 128'(keys_valid_o), 128'd0);
    checkOutput("reset_busy", 128'(busy_o), 128'd0);
    checkOutput("reset_rdata", round_key_o, 128'h0);
    rst = 1'b0;
    cycle_count = 0;

    // Handshake: first key at cycle 5, a different key at cycle 20 while busy.
    while (cycle_count < 5) tick();
    applyStimulus(1'b1, STD_KEY);
    t_acc = cycle_count;
    checkOutput("acc_busy", 128'(busy_o), 128'd1);
    checkOutput("acc_ready", 128'(key_ready_o), 128'd0);
    key_idx_i = 4'd3;
    repeat (7) tick();
    readKey(4'd3, 128'h0, "k3_read_during_write");
    readKey(4'd3, STD_K3, "k3_read_after_write");
    while (cycle_count < 20) tick();
    checkOutput("busy_ready_low", 128'(key_ready_o), 128'd0);
    applyStimulus(1'b1, ALT_KEY);
    waitDone(t_acc, "first_accept_latency");
    runStdTable("hs");

    // Re-key while DONE: flag drops at once, K1/K2 replaced on the accept edge.
    applyStimulus(1'b1, ALT_KEY);
    t_acc = cycle_count;
    checkOutput("rekey_valid_drop", 128'(keys_valid_o), 128'd0);
    readKey(4'd1, ALT_KEY[255:128], "rekey_k1_immediate");
    readKey(4'd2, ALT_KEY[127:0], "rekey_k2_immediate");
    waitDone(t_acc, "rekey_latency");
    readKey(4'd1, ALT_KEY[255:128], "rekey_k1_done");
    applyStimulus(1'b1, STD_KEY);
    t_acc = cycle_count;
    waitDone(t_acc, "rekey_back_latency");
    readKey(4'd10, STD_K10, "rekey_back_k10");

    // Reset at the 17th expansion cycle: everything wiped, then a clean expansion.
    applyStimulus(1'b1, ALT_KEY);
    t_acc = cycle_count;
    while (cycle_count < t_acc + 16) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("midrst_valid", 128'(keys_valid_o), 128'd0);
    checkOutput("midrst_ready", 128'(key_ready_o), 128'd1);
    checkOutput("midrst_busy", 128'(busy_o), 128'd0);
    checkOutput("midrst_rdata", round_key_o, 128'h0);
    for (int k = 1; k <= 10; k++) readKey(4'(k), 128'h0, $sformatf("midrst_k%0d", k));
    applyStimulus(1'b1, STD_KEY);
    t_acc = cycle_count;
    waitDone(t_acc, "after_rst_latency");
    runStdTable("post_rst");

`ifdef GRASS_KEY_ZEROIZE_EN
    // Zeroize together with a key offer in DONE: wipe wins, nothing starts.
    zeroize_i = 1'b1;
    applyStimulus(1'b1, ALT_KEY);
    zeroize_i = 1'b0;
    checkOutput("zero_valid", 128'(keys_valid_o), 128'd0);
    checkOutput("zero_busy", 128'(busy_o), 128'd0);
    checkOutput("zero_ready", 128'(key_ready_o), 128'd1);
    checkOutput("zero_rdata", round_key_o, 128'h0);
    readKey(4'd1, 128'h0, "zero_k1");
    readKey(4'd10, 128'h0, "zero_k10");
    checkOutput("zero_still_idle", 128'(busy_o), 128'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
